wfg_core_gen2: RTL and testbench
================================

WFG_CORE_GEN2 -- requirements
Module: wfg_core_gen2

Interface
REQ-001 SHALL have parameter SUBCYC_W, default 16, width of subcycle divider.
REQ-002 SHALL have parameter CNT_W, default 8, width of subcycle counter, phase and burst fields.
REQ-003 SHALL have parameter SYNC_CH, default 4, number of phase-offset sync channels (1..16).
REQ-004 SHALL have port clk  in  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port en_i  in  1  run enable.
REQ-007 SHALL have port mode_i  in  1  0 continuous, 1 one-shot burst.
REQ-008 SHALL have port subcycle_div_i  in  SUBCYC_W  subcycle period minus 1, in clocks.
REQ-009 SHALL have port sync_cnt_i  in  CNT_W  subcycles per sync minus 1.
REQ-010 SHALL have port burst_len_i  in  CNT_W  sync periods per one-shot burst.
REQ-011 SHALL have port phase_i  in  SYNC_CH*CNT_W  per-channel subcycle index; channel k at bits [k*CNT_W +: CNT_W].
REQ-012 SHALL have port wfg_core_sync_o  out  1  sync pulse.
REQ-013 SHALL have port wfg_core_subcycle_o  out  1  subcycle pulse.
REQ-014 SHALL have port wfg_core_start_o  out  1  start pulse.
REQ-015 SHALL have port wfg_core_subcycle_cnt_o  out  CNT_W  current subcycle index.
REQ-016 SHALL have port wfg_core_sync_ch_o  out  SYNC_CH  per-channel phase pulses.
REQ-017 SHALL have port active_o  out  1  running indication.
REQ-018 SHALL have port done_o  out  1  one-shot completion pulse.

Function
REQ-019 SHALL have states IDLE and RUN; all outputs registered; all pulses exactly one clock wide.
REQ-020 IDLE->RUN SHALL occur on the first edge sampling en_i=1 with en_i sampled 0 on the previous edge (rising edge detect); a level held high after one-shot completion SHALL NOT restart.
REQ-021 On IDLE->RUN: start_o=1, active_o=1, prescaler=0, subcycle_cnt=0, burst count=0; div, cnt, burst, phase, mode SHALL be captured into shadow registers.
REQ-022 In RUN: prescaler SHALL increment each clock; when prescaler==div_q it SHALL reload 0 and subcycle_o SHALL pulse, giving period div_q+1 clocks; first subcycle pulse D+1 clocks after start pulse.
REQ-023 On each subcycle pulse: subcycle_cnt SHALL increment, or wrap to 0 when equal to cnt_q; wrap SHALL assert sync_o in the same cycle as subcycle_o.
REQ-024 wfg_core_subcycle_cnt_o SHALL show the post-update value, coincident with subcycle_o.
REQ-025 sync_ch_o[k] SHALL pulse with subcycle_o when the post-update subcycle_cnt equals phase_q[k]; phase 0 coincides with sync_o; phase > cnt_q SHALL never fire.
REQ-026 Continuous mode: shadow registers SHALL reload from inputs in the sync_o cycle; changes take effect from the next subcycle period.
REQ-027 One-shot mode: shadows SHALL be held; sync pulses counted; on the burst_len_q-th sync_o, done_o SHALL pulse in the same cycle and the next cycle SHALL be IDLE with active_o=0; burst_len 0 SHALL be treated as 1.
REQ-028 en_i=0 in RUN SHALL return to IDLE on that edge: active_o=0, counters cleared, no done_o, no pulses.
REQ-029 div=0 SHALL yield subcycle_o every clock; cnt=0 SHALL yield sync_o on every subcycle pulse.
REQ-030 Counters SHALL be exactly SUBCYC_W/CNT_W wide; no overflow beyond compare values.

Reset
REQ-031 rst_n low SHALL asynchronously force IDLE, all counters and shadows to 0, all outputs 0; release synchronous to clk; en_i high at release SHALL NOT start (previous-en register resets to 1).

Structure
REQ-032 Package wfg_core_gen2_pkg SHALL hold the state enum and mode enum (MODE_CONT, MODE_ONESHOT).
REQ-033 Prescaler SHALL be sub-module wfg_core_gen2_div (clear, enable, div compare, tick out).

Verification
REQ-034 Continuous, div=3, cnt=2, phases {0,1,2,5}: subcycle_o every 4 clocks, sync_o every 12, cnt 1,2,0; ch0 with sync, ch3 never.
REQ-035 One-shot, div=1, cnt=1, burst=3: exactly 3 sync_o, done_o with 3rd, active_o low next clock, no restart while en_i high.
REQ-036 div=0, cnt=0: subcycle_o and sync_o high every clock after start.
REQ-037 Continuous, change div 3->7 mid-period: new 8-clock period starts only after next sync_o.
REQ-038 en_i dropped mid-burst, then rst_n pulsed mid-run: immediate idle, no done_o, all outputs 0, restart only on fresh en_i edge.

Source files
------------

// File: rtl/wfg_core_gen2_pkg.sv
// -----------------------------------------------------------------------------
// wfg_core_gen2_pkg : shared types and defaults for the waveform timing core
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

package wfg_core_gen2_pkg;

   localparam int DEF_SUBCYC_W = 16;
   localparam int DEF_CNT_W    = 8;
   localparam int DEF_SYNC_CH  = 4;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   typedef enum logic {
      MODE_CONT    = 1'b0,
      MODE_ONESHOT = 1'b1
   } mode_e;

endpackage

`default_nettype wire

// File: rtl/wfg_core_gen2_div.sv
// -----------------------------------------------------------------------------
// wfg_core_gen2_div : subcycle prescaler, ticks when the count reaches div_i
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module wfg_core_gen2_div #(
   parameter int SUBCYC_W = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                clr_i,
   input  logic                en_i,
   input  logic [SUBCYC_W-1:0] div_i,
   output logic                tick_o
);

   logic [SUBCYC_W-1:0] presc_q;
   logic [SUBCYC_W-1:0] presc_d;

   always_comb begin
      tick_o  = en_i && !clr_i && (presc_q == div_i);
      presc_d = presc_q;
      if (clr_i) begin
         presc_d = '0;
      end else if (en_i) begin
         // reload on the tick so the count never exceeds the compare value
         presc_d = tick_o ? '0 : presc_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc_q <= '0;
      end else begin
         presc_q <= presc_d;
      end
   end

endmodule

`default_nettype wire

// File: rtl/wfg_core_gen2.sv
// -----------------------------------------------------------------------------
// wfg_core_gen2 : waveform generator timing core (subcycle, sync, phase pulses)
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module wfg_core_gen2
   import wfg_core_gen2_pkg::*;
#(
   parameter int SUBCYC_W = DEF_SUBCYC_W,
   parameter int CNT_W    = DEF_CNT_W,
   parameter int SYNC_CH  = DEF_SYNC_CH
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     en_i,
   input  logic                     mode_i,
   input  logic [SUBCYC_W-1:0]      subcycle_div_i,
   input  logic [CNT_W-1:0]         sync_cnt_i,
   input  logic [CNT_W-1:0]         burst_len_i,
   input  logic [SYNC_CH*CNT_W-1:0] phase_i,
   output logic                     wfg_core_sync_o,
   output logic                     wfg_core_subcycle_o,
   output logic                     wfg_core_start_o,
   output logic [CNT_W-1:0]         wfg_core_subcycle_cnt_o,
   output logic [SYNC_CH-1:0]       wfg_core_sync_ch_o,
   output logic                     active_o,
   output logic                     done_o
);

   state_e                   state_q,     state_d;
   logic                     en_prev_q,   en_prev_d;
   mode_e                    mode_q,      mode_d;
   logic [SUBCYC_W-1:0]      div_q,       div_d;
   logic [CNT_W-1:0]         cnt_q,       cnt_d;
   logic [CNT_W-1:0]         burst_q,     burst_d;
   logic [SYNC_CH*CNT_W-1:0] phase_q,     phase_d;
   logic [CNT_W-1:0]         subcnt_q,    subcnt_d;
   logic [CNT_W-1:0]         burst_cnt_q, burst_cnt_d;
   logic                     sync_q,      sync_d;
   logic                     sub_q,       sub_d;
   logic                     start_q,     start_d;
   logic                     active_q,    active_d;
   logic                     done_q,      done_d;
   logic [SYNC_CH-1:0]       ch_q,        ch_d;

   logic                     w_run;
   logic                     w_tick;
   logic                     w_wrap;
   logic [CNT_W-1:0]         w_subcnt_nxt;
   logic [CNT_W-1:0]         w_burst_nxt;
   logic [CNT_W-1:0]         w_burst_eff;
   logic [SYNC_CH-1:0]       w_ch_hit;

   assign w_run = (state_q == ST_RUN);

   wfg_core_gen2_div #(
      .SUBCYC_W (SUBCYC_W)
   ) u_div (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr_i  (!en_i),
      .en_i   (w_run),
      .div_i  (div_q),
      .tick_o (w_tick)
   );

   assign w_wrap       = (subcnt_q == cnt_q);
   assign w_subcnt_nxt = w_wrap ? '0 : subcnt_q + 1'b1;
   assign w_burst_nxt  = burst_cnt_q + 1'b1;
   // a burst length of zero still runs one sync period
   assign w_burst_eff  = (burst_q == '0) ? {{(CNT_W-1){1'b0}}, 1'b1} : burst_q;

   generate
      for (genvar k = 0; k < SYNC_CH; k++) begin : g_ch
         assign w_ch_hit[k] = (w_subcnt_nxt == phase_q[k*CNT_W +: CNT_W]);
      end
   endgenerate

   always_comb begin
      state_d     = state_q;
      en_prev_d   = en_i;
      mode_d      = mode_q;
      div_d       = div_q;
      cnt_d       = cnt_q;
      burst_d     = burst_q;
      phase_d     = phase_q;
      subcnt_d    = subcnt_q;
      burst_cnt_d = burst_cnt_q;
      sync_d      = 1'b0;
      sub_d       = 1'b0;
      start_d     = 1'b0;
      done_d      = 1'b0;
      ch_d        = '0;
      active_d    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            subcnt_d    = '0;
            burst_cnt_d = '0;
            if (en_i && !en_prev_q) begin
               state_d  = ST_RUN;
               start_d  = 1'b1;
               active_d = 1'b1;
               mode_d   = mode_e'(mode_i);
               div_d    = subcycle_div_i;
               cnt_d    = sync_cnt_i;
               burst_d  = burst_len_i;
               phase_d  = phase_i;
            end
         end

         ST_RUN: begin
            if (!en_i) begin
               state_d     = ST_IDLE;
               subcnt_d    = '0;
               burst_cnt_d = '0;
            end else begin
               active_d = 1'b1;
               if (w_tick) begin
                  sub_d    = 1'b1;
                  subcnt_d = w_subcnt_nxt;
                  ch_d     = w_ch_hit;
                  if (w_wrap) begin
                     sync_d = 1'b1;
                     if (mode_q == MODE_ONESHOT) begin
                        burst_cnt_d = w_burst_nxt;
                        // active stays high for this cycle; IDLE shows next cycle
                        if (w_burst_nxt == w_burst_eff) begin
                           done_d      = 1'b1;
                           state_d     = ST_IDLE;
                           burst_cnt_d = '0;
                        end
                     end else begin
                        div_d   = subcycle_div_i;
                        cnt_d   = sync_cnt_i;
                        burst_d = burst_len_i;
                        phase_d = phase_i;
                     end
                  end
               end
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         en_prev_q   <= 1'b1;
         mode_q      <= MODE_CONT;
         div_q       <= '0;
         cnt_q       <= '0;
         burst_q     <= '0;
         phase_q     <= '0;
         subcnt_q    <= '0;
         burst_cnt_q <= '0;
         sync_q      <= 1'b0;
         sub_q       <= 1'b0;
         start_q     <= 1'b0;
         active_q    <= 1'b0;
         done_q      <= 1'b0;
         ch_q        <= '0;
      end else begin
         state_q     <= state_d;
         en_prev_q   <= en_prev_d;
         mode_q      <= mode_d;
         div_q       <= div_d;
         cnt_q       <= cnt_d;
         burst_q     <= burst_d;
         phase_q     <= phase_d;
         subcnt_q    <= subcnt_d;
         burst_cnt_q <= burst_cnt_d;
         sync_q      <= sync_d;
         sub_q       <= sub_d;
         start_q     <= start_d;
         active_q    <= active_d;
         done_q      <= done_d;
         ch_q        <= ch_d;
      end
   end

   assign wfg_core_sync_o         = sync_q;
   assign wfg_core_subcycle_o     = sub_q;
   assign wfg_core_start_o        = start_q;
   assign wfg_core_subcycle_cnt_o = subcnt_q;
   assign wfg_core_sync_ch_o      = ch_q;
   assign active_o                = active_q;
   assign done_o                  = done_q;

endmodule

`default_nettype wire

// File: tb/tb_wfg_core_gen2.sv
// -----------------------------------------------------------------------------
// tb_wfg_core_gen2 : directed and randomized checks against a pulse-timing model
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module tb_wfg_core_gen2;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        en_i;
   logic        mode_i;
   logic [15:0] subcycle_div_i;
   logic [7:0]  sync_cnt_i;
   logic [7:0]  burst_len_i;
   logic [31:0] phase_i;
   logic        wfg_core_sync_o;
   logic        wfg_core_subcycle_o;
   logic        wfg_core_start_o;
   logic [7:0]  wfg_core_subcycle_cnt_o;
   logic [3:0]  wfg_core_sync_ch_o;
   logic        active_o;
   logic        done_o;

   wfg_core_gen2 #(
      .SUBCYC_W (16),
      .CNT_W    (8),
      .SYNC_CH  (4)
   ) dut (
      .clk                     (clk),
      .rst_n                   (rst_n),
      .en_i                    (en_i),
      .mode_i                  (mode_i),
      .subcycle_div_i          (subcycle_div_i),
      .sync_cnt_i              (sync_cnt_i),
      .burst_len_i             (burst_len_i),
      .phase_i                 (phase_i),
      .wfg_core_sync_o         (wfg_core_sync_o),
      .wfg_core_subcycle_o     (wfg_core_subcycle_o),
      .wfg_core_start_o        (wfg_core_start_o),
      .wfg_core_subcycle_cnt_o (wfg_core_subcycle_cnt_o),
      .wfg_core_sync_ch_o      (wfg_core_sync_ch_o),
      .active_o                (active_o),
      .done_o                  (done_o)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Reference model: pulse times derived arithmetically from the segment start.
   int t = 0;
   bit m_active = 1'b0;
   bit m_prev_en = 1'b1;
   int m_seg, m_D, m_C, m_B, m_mode, m_syncs;
   int m_ph[4];
   bit e_sync, e_sub, e_start, e_active, e_done;
   int e_cnt;
   bit [3:0] e_ch;

   // observation counters for directed steps
   int n_sync, n_done, n_sub, n_ch3, n_act, n_start;
   int sub_times[$];

   task automatic model_capture();
      m_D    = int'(subcycle_div_i);
      m_C    = int'(sync_cnt_i);
      m_B    = int'(burst_len_i);
      m_mode = int'(mode_i);
      for (int k = 0; k < 4; k++) m_ph[k] = int'(phase_i[k*8 +: 8]);
   endtask

   task automatic model_reset();
      m_active  = 1'b0;
      m_prev_en = 1'b1;
   endtask

   task automatic model_edge();
      int e, per, n, idx, blen;
      e_sync = 0; e_sub = 0; e_start = 0; e_active = 0; e_done = 0;
      e_cnt = 0; e_ch = '0;
      t++;
      if (!rst_n) begin
         model_reset();
         return;
      end
      if (!m_active) begin
         if (en_i && !m_prev_en) begin
            model_capture();
            m_seg = t; m_syncs = 0; m_active = 1'b1;
            e_start = 1; e_active = 1;
         end
      end else if (!en_i) begin
         m_active = 1'b0;
      end else begin
         e   = t - m_seg;
         per = m_D + 1;
         n   = e / per;
         idx = n % (m_C + 1);
         e_active = 1;
         e_cnt    = idx;
         if (e % per == 0) begin
            e_sub = 1;
            for (int k = 0; k < 4; k++) e_ch[k] = (idx == m_ph[k]);
            if (idx == 0) begin
               e_sync = 1;
               m_syncs++;
               blen = (m_B == 0) ? 1 : m_B;
               if (m_mode == 1) begin
                  if (m_syncs >= blen) begin
                     e_done = 1;
                     m_active = 1'b0;
                  end
               end else begin
                  model_capture();
                  m_seg = t;
               end
            end
         end
      end
      m_prev_en = en_i;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h t=%0d", tag, obs, exp, t);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      model_edge();
      #1;
      check("pulses",
            32'({wfg_core_sync_o, wfg_core_subcycle_o, wfg_core_start_o, active_o, done_o}),
            32'({e_sync, e_sub, e_start, e_active, e_done}));
      check("subcycle_cnt", 32'(wfg_core_subcycle_cnt_o), 32'(e_cnt));
      check("sync_ch", 32'(wfg_core_sync_ch_o), 32'(e_ch));
      if (wfg_core_sync_o)     n_sync++;
      if (done_o)              n_done++;
      if (wfg_core_subcycle_o) begin n_sub++; sub_times.push_back(t); end
      if (wfg_core_sync_ch_o[3]) n_ch3++;
      if (active_o)            n_act++;
      if (wfg_core_start_o)    n_start++;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cyc();
   endtask

   task automatic clr_obs();
      n_sync = 0; n_done = 0; n_sub = 0; n_ch3 = 0; n_act = 0; n_start = 0;
      sub_times.delete();
   endtask

   task automatic cfg(input bit md, input int dv, input int cn, input int bl,
                      input int p0, input int p1, input int p2, input int p3);
      mode_i         = md;
      subcycle_div_i = 16'(dv);
      sync_cnt_i     = 8'(cn);
      burst_len_i    = 8'(bl);
      phase_i        = {8'(p3), 8'(p2), 8'(p1), 8'(p0)};
   endtask

   initial begin
      rst_n = 1'b0; en_i = 1'b1;
      cfg(0, 0, 0, 0, 0, 0, 0, 0);
      model_reset();
      clr_obs();

      // reset state, with en_i already high across the release
      run(3);
      rst_n = 1'b1;
      run(5);
      check("no_start_after_reset", 32'(n_start), 32'd0);

      // continuous, div=3 cnt=2 phases {0,1,2,5}
      en_i = 1'b0;
      cfg(0, 3, 2, 0, 0, 1, 2, 5);
      run(1);
      en_i = 1'b1;
      clr_obs();
      run(41);
      check("cont_sync_count", 32'(n_sync), 32'd3);
      check("cont_sub_count", 32'(n_sub), 32'd10);
      check("cont_ch3_never", 32'(n_ch3), 32'd0);

      // one-shot burst of three
      en_i = 1'b0;
      run(1);
      cfg(1, 1, 1, 3, 0, 1, 0, 1);
      en_i = 1'b1;
      clr_obs();
      run(20);
      check("oneshot_sync_count", 32'(n_sync), 32'd3);
      check("oneshot_done_count", 32'(n_done), 32'd1);
      clr_obs();
      run(10);
      check("oneshot_no_restart", 32'(n_act), 32'd0);

      // div=0 cnt=0: pulses every clock after start
      en_i = 1'b0;
      run(1);
      cfg(0, 0, 0, 0, 0, 0, 0, 0);
      en_i = 1'b1;
      run(1);
      clr_obs();
      run(10);
      check("div0_sub_every_clock", 32'(n_sub), 32'd10);
      check("cnt0_sync_every_sub", 32'(n_sync), 32'd10);

      // div change 3 -> 7 mid-period takes effect after the next sync
      en_i = 1'b0;
      run(1);
      cfg(0, 3, 2, 0, 0, 1, 2, 3);
      en_i = 1'b1;
      clr_obs();
      run(7);
      subcycle_div_i = 16'd7;
      run(40);
      check("divchg_gap_before_sync", 32'(sub_times[2] - sub_times[1]), 32'd4);
      check("divchg_gap_after_sync", 32'(sub_times[3] - sub_times[2]), 32'd8);

      // en_i dropped mid-burst
      en_i = 1'b0;
      run(1);
      cfg(1, 2, 3, 4, 0, 1, 2, 3);
      en_i = 1'b1;
      run(15);
      en_i = 1'b0;
      clr_obs();
      run(6);
      check("drop_no_done", 32'(n_done), 32'd0);
      check("drop_idle", 32'(n_act), 32'd0);

      // asynchronous reset mid-run, then restart only on a fresh edge
      en_i = 1'b1;
      run(7);
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      check("async_rst_outputs",
            32'({wfg_core_sync_o, wfg_core_subcycle_o, wfg_core_start_o, active_o, done_o,
                 wfg_core_subcycle_cnt_o, wfg_core_sync_ch_o}), 32'd0);
      run(2);
      rst_n = 1'b1;
      clr_obs();
      run(5);
      check("rst_no_restart", 32'(n_act), 32'd0);
      en_i = 1'b0;
      run(1);
      en_i = 1'b1;
      clr_obs();
      run(1);
      check("fresh_edge_start", 32'(n_start), 32'd1);

      // randomized configurations and enable toggles
      for (int r = 0; r < 12; r++) begin
         int cn;
         en_i = 1'b0;
         run(1);
         cn = int'($urandom_range(0, 4));
         cfg(1'($urandom_range(0, 1)), int'($urandom_range(0, 5)), cn, int'($urandom_range(0, 3)),
             int'($urandom_range(0, cn + 1)), int'($urandom_range(0, cn + 1)),
             int'($urandom_range(0, cn + 1)), int'($urandom_range(0, cn + 1)));
         en_i = 1'b1;
         for (int i = 0; i < int'($urandom_range(20, 80)); i++) begin
            cyc();
            if ($urandom_range(0, 9) == 0) begin
               subcycle_div_i = 16'($urandom_range(0, 5));
               sync_cnt_i     = 8'($urandom_range(0, 4));
               phase_i        = $urandom & 32'h0707_0707;
            end
            if ($urandom_range(0, 39) == 0) en_i = ~en_i;
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
